// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_pkg                                                   |
// | Description : Shared decoder op codes, FSM state type and op-class helpers |
// |               for the RV32M multiply/divide unit.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package muldiv_pkg;

  // Decoder control codes handled by the multiply/divide unit.
  localparam logic [4:0] C_OP_MUL    = 5'h0A;
  localparam logic [4:0] C_OP_MULH   = 5'h0B;
  localparam logic [4:0] C_OP_MULHSU = 5'h0C;
  localparam logic [4:0] C_OP_MULHU  = 5'h0D;
  localparam logic [4:0] C_OP_DIV    = 5'h0E;
  localparam logic [4:0] C_OP_DIVU   = 5'h0F;
  localparam logic [4:0] C_OP_REM    = 5'h10;
  localparam logic [4:0] C_OP_REMU   = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  // True for any code this unit accepts.
  function automatic logic is_muldiv_op(input logic [4:0] control);
    return (control >= C_OP_MUL) && (control <= C_OP_REMU);
  endfunction

  // True for the four divide/remainder codes.
  function automatic logic is_div_op(input logic [4:0] control);
    return (control >= C_OP_DIV) && (control <= C_OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_sign_fix                                              |
// | Description : Combinational operand magnitude/sign capture and final       |
// |               result negation with divide special-case selection.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  // Operand capture side (raw decoder inputs)
  input  logic [4:0]        ctrl_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   mag_a_o,
  output logic [XLEN-1:0]   mag_b_o,
  output logic              neg_a_o,
  output logic              neg_b_o,
  // Result side (latched op state plus final datapath values)
  input  logic [4:0]        op_i,
  input  logic              fneg_a_i,
  input  logic              fneg_b_i,
  input  logic [XLEN-1:0]   fmag_a_i,
  input  logic [XLEN-1:0]   fmag_b_i,
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic [XLEN-1:0]   rem_i,
  output logic [XLEN-1:0]   result_o
);

  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_ONE     = XLEN'(1);

  logic              w_sgn_a;
  logic              w_sgn_b;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_orig_a;
  logic              w_div_zero;
  logic              w_ovf;

  // Signed operand positions: MULH both, MULHSU rs1 only, DIV/REM both.
  always_comb begin
    w_sgn_a = (ctrl_i == C_OP_MULH) || (ctrl_i == C_OP_MULHSU) ||
              (ctrl_i == C_OP_DIV)  || (ctrl_i == C_OP_REM);
    w_sgn_b = (ctrl_i == C_OP_MULH) || (ctrl_i == C_OP_DIV) ||
              (ctrl_i == C_OP_REM);
    neg_a_o = w_sgn_a & a_i[XLEN-1];
    neg_b_o = w_sgn_b & b_i[XLEN-1];
    mag_a_o = neg_a_o ? -a_i : a_i;
    mag_b_o = neg_b_o ? -b_i : b_i;
  end

  // Restore signs on the unsigned core results and pick the architectural result.
  always_comb begin
    w_prod_fix = (fneg_a_i ^ fneg_b_i) ? -prod_i : prod_i;
    w_quo_fix  = (fneg_a_i ^ fneg_b_i) ? -quo_i  : quo_i;
    w_rem_fix  = fneg_a_i ? -rem_i : rem_i;
    w_orig_a   = fneg_a_i ? -fmag_a_i : fmag_a_i;
    w_div_zero = (fmag_b_i == '0);
    // Only signed divides can set both flags, so this is the INT_MIN / -1 case.
    w_ovf      = fneg_a_i && fneg_b_i && (fmag_a_i == C_MIN_NEG) && (fmag_b_i == C_ONE);
    result_o   = '0;
    case (op_i)
      C_OP_MUL:                           result_o = w_prod_fix[XLEN-1:0];
      C_OP_MULH, C_OP_MULHSU, C_OP_MULHU: result_o = w_prod_fix[2*XLEN-1:XLEN];
      C_OP_DIV, C_OP_DIVU: begin
        if (w_div_zero)  result_o = '1;
        else if (w_ovf)  result_o = C_MIN_NEG;
        else             result_o = w_quo_fix;
      end
      C_OP_REM, C_OP_REMU: begin
        if (w_div_zero)  result_o = w_orig_a;
        else if (w_ovf)  result_o = '0;
        else             result_o = w_rem_fix;
      end
      default:           result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_unit                                                  |
// | Description : Iterative radix-2 RV32M multiply/divide unit, fixed latency  |
// |               XLEN+1 cycles, one operation in flight.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [4:0]      control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int              CW        = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   C_CNT_MAX = CW'(XLEN);

  muldiv_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic [4:0]        tag_q, tag_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  // Multiply: full product. Divide: low half holds dividend bits shifting out
  // and quotient bits shifting in.
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              w_accept;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_fix_result;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rshift;
  logic [XLEN:0]     w_diff;

  muldiv_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .ctrl_i   (control),
    .a_i      (op_a),
    .b_i      (op_b),
    .mag_a_o  (w_mag_a),
    .mag_b_o  (w_mag_b),
    .neg_a_o  (w_neg_a),
    .neg_b_o  (w_neg_b),
    .op_i     (op_q),
    .fneg_a_i (neg_a_q),
    .fneg_b_i (neg_b_q),
    .fmag_a_i (mag_a_q),
    .fmag_b_i (mag_b_q),
    .prod_i   (prod_q),
    .quo_i    (prod_q[XLEN-1:0]),
    .rem_i    (rem_q),
    .result_o (w_fix_result)
  );

  assign w_accept = start && !kill && is_muldiv_op(control) && (state_q != ST_RUN);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign rd_out   = rd_out_q;

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    w_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
    w_rshift = {rem_q, prod_q[XLEN-1]};
    w_diff   = w_rshift - {1'b0, mag_b_q};
  end

  // Next-state, counter and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (cnt_q == C_CNT_MAX) begin
          state_d  = ST_DONE;
          result_d = w_fix_result;
          rd_out_d = tag_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (is_div_op(op_q)) begin
            // A clear borrow bit means the divisor fits: keep the difference.
            if (!w_diff[XLEN]) begin
              rem_d  = w_diff[XLEN-1:0];
              prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], 1'b1};
            end else begin
              rem_d  = w_rshift[XLEN-1:0];
              prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], 1'b0};
            end
          end else begin
            prod_d = {w_sum, prod_q[XLEN-1:1]};
          end
        end
      end
      ST_DONE: begin
        state_d = w_accept ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_accept) begin
      op_d    = control;
      tag_d   = rd_in;
      neg_a_d = w_neg_a;
      neg_b_d = w_neg_b;
      mag_a_d = w_mag_a;
      mag_b_d = w_mag_b;
      cnt_d   = '0;
      rem_d   = '0;
      // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
      prod_d  = is_div_op(control) ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the RV32M instructions. Sits in the execute stage directly downstream of the instruction decoder. It consumes the decoder's 5-bit `control` codes 0x0A–0x11 plus the two register operands, and returns a registered result with a one-cycle `done` pulse and the destination register tag for writeback. Radix-2, fixed latency, one operation in flight.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0 and `control` is in 0x0A–0x11.
- `kill`  in  1  abort (pipeline flush); has priority over `start`.
- `control`  in  5  decoder op code:
  - 0x0A MUL, 0x0B MULH, 0x0C MULHSU, 0x0D MULHU
  - 0x0E DIV, 0x0F DIVU, 0x10 REM, 0x11 REMU
- `op_a`  in  XLEN  rs1 value (dividend / multiplicand).
- `op_b`  in  XLEN  rs2 value (divisor / multiplier).
- `rd_in`  in  5  destination tag, captured at accept.
- `busy`  out  1  high in RUN state.
- `done`  out  1  one-cycle pulse; `result` and `rd_out` are valid in that cycle.
- `result`  out  XLEN  registered result; held until the next `done`.
- `rd_out`  out  5  captured tag; held with `result`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE, with `start`, a legal code and no `kill`:
  - latch the op, tag and operand signs;
  - latch |op_a| and |op_b| (magnitude taken only for signed operand positions: MULH both, MULHSU op_a only, DIV/REM both);
  - clear the counter; go to RUN.
- Illegal `control` with `start`: ignored, no state change.
- RUN: one iteration per cycle.
  - Multiply: shift-add into a 2·XLEN product register.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - After `XLEN` iterations go to DONE.
- Entering DONE: apply the sign fix, then select the result.
  - MUL: low half. MULH/MULHSU/MULHU: high half.
  - Product negated when the operand signs differ (MULHSU: sign of op_a only).
  - DIV quotient negated when the signs differ; REM remainder takes the dividend's sign.
- Special cases (same latency, no early exit):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- DONE lasts one cycle, then IDLE, unless a new `start` is accepted there (back-to-back).
- `kill` in RUN or DONE: next state IDLE, no `done` is issued for that op, `result` unchanged.
- `start` while `busy`=1: ignored.

## Timing
- Accept at edge N; `busy`=1 from edge N through edge N+32.
- `done`=1 after edge N+33, for exactly one cycle. Latency is XLEN+1 = 33 cycles.
- Back-to-back: `start` in the DONE cycle is accepted at that edge; next `done` 33 cycles later.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter 0.
- Reset mid-operation: IDLE on the next edge, no `done`.
- Reset has priority over `kill`, which has priority over `start`.
- Counter width `$clog2(XLEN)+1`; no wrap past `XLEN`.
- Widths:
  - Product register 2·XLEN.
  - Partial remainder XLEN+1 bits, to keep the borrow.
  - Sign negation is two's complement at the target width.

## Structure
- Shared package `muldiv_pkg`:
  - localparams for the eight control codes (the same values the decoder emits);
  - state enum `muldiv_state_t`;
  - helper function `is_muldiv_op(control)`.
- One natural combinational sub-module, `muldiv_sign_fix`: operand magnitude/sign capture and final negation plus special-case selection. The iterative datapath and FSM stay in `muldiv_unit`.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD, start at edge N → `done` after edge N+33 with `result`=0xFFFFFFEB and `rd_out`=`rd_in`; `busy` high for edges N..N+32.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0; all at 33-cycle latency.
- `kill` 10 cycles into an op → IDLE next edge, no `done`, `result` holds its previous value. A `start` during `busy` is ignored. `start` with `control`=0x05 → no accept.
- Back-to-back start in the DONE cycle → second `done` exactly 33 cycles after the first. `rst` asserted mid-RUN → all outputs 0 on the next edge, no `done`.
